// File: rtl/toy_loader_pkg.sv
// Shared types and defaults for the toy loader sequencer.
// Imported by the arbiter and the sequencer top.
package toy_loader_pkg;

    localparam int N_REQ_DEF      = 4;
    localparam int DATA_W_DEF     = 8;
    localparam int CLR_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        LOAD  = 2'd2,
        CLEAR = 2'd3
    } state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/toy_loader_rr_arbiter.sv
// Combinational round-robin arbiter.
// Search starts at ptr_i and wraps; the first set request wins.
module rr_arbiter
    import toy_loader_pkg::*;
#(
    parameter  int N  = N_REQ_DEF,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req_i[(int'(ptr_i) + k) % N]) begin
                found = 1'b1;
                gnt_o[(int'(ptr_i) + k) % N] = 1'b1;
                idx_o = IW'((int'(ptr_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/toy_loader_sequencer.sv
// Shares one toy loader between N_REQ requesters.
// IDLE arbitrates, SETUP presents data, LOAD strobes, CLEAR resets.
module toy_loader_sequencer
    import toy_loader_pkg::*;
#(
    parameter  int N_REQ      = N_REQ_DEF,
    parameter  int DATA_W     = DATA_W_DEF,
    parameter  int CLR_CYCLES = CLR_CYCLES_DEF,
    localparam int IW         = idx_w(N_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      clear_req,
    output logic                      clear_done,
    output logic [DATA_W-1:0]         ld_data,
    output logic                      ld_load_enable,
    output logic                      ld_reset,
    output logic                      busy,
    output logic [IW-1:0]             grant_id,
    output logic [15:0]               load_count
);

    localparam int CW = idx_w(CLR_CYCLES);

    state_e              state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       gid_q, gid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                en_q, en_d;
    logic                lrst_q, lrst_d;
    logic [N_REQ-1:0]    rdy_q, rdy_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [CW-1:0]       clr_q, clr_d;

    logic [N_REQ-1:0]    arb_gnt;
    logic [IW-1:0]       arb_idx;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        data_d  = data_q;
        en_d    = 1'b0;
        lrst_d  = 1'b0;
        rdy_d   = '0;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        clr_d   = clr_q;
        unique case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    lrst_d  = 1'b1;
                    cnt_d   = '0;
                    clr_d   = '0;
                end else if (|req_valid) begin
                    state_d = SETUP;
                    rdy_d   = arb_gnt;
                    gid_d   = arb_idx;
                    data_d  = req_data[int'(arb_idx)*DATA_W +: DATA_W];
                    ptr_d   = (arb_idx == IW'(N_REQ - 1)) ? '0
                            : arb_idx + IW'(1);
                end
            end
            SETUP: begin
                state_d = LOAD;
                en_d    = 1'b1;
            end
            LOAD: begin
                state_d = IDLE;
                cnt_d   = cnt_q + 16'd1;
            end
            CLEAR: begin
                if (clr_q == CW'(CLR_CYCLES - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    lrst_d = 1'b1;
                    clr_d  = clr_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            lrst_q  <= 1'b0;
            rdy_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            data_q  <= data_d;
            en_q    <= en_d;
            lrst_q  <= lrst_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            clr_q   <= clr_d;
        end
    end

    assign req_ready      = rdy_q;
    assign clear_done     = done_q;
    assign ld_data        = data_q;
    assign ld_load_enable = en_q;
    assign ld_reset       = lrst_q;
    assign busy           = busy_q;
    assign grant_id       = gid_q;
    assign load_count     = cnt_q;

endmodule

// File: doc/toy_loader_sequencer.md
TOY_LOADER_SEQUENCER -- requirements
Module: toy_loader_sequencer

Interface
REQ-001 Parameter N_REQ, 4, number of requesters sharing one stupid_toy_loader.
REQ-002 Parameter DATA_W, 8, loader data width.
REQ-003 Parameter CLR_CYCLES, 2, loader-reset pulse length in clk cycles (>=1).
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  N_REQ  per-requester load request.
REQ-007 req_data  in  N_REQ*DATA_W  packed request data; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 req_ready  out  N_REQ  one-hot grant/accept strobe.
REQ-009 clear_req  in  1  request loader reset sequence (level).
REQ-010 clear_done  out  1  one-cycle pulse when clear sequence completes.
REQ-011 ld_data  out  DATA_W  to loader data.
REQ-012 ld_load_enable  out  1  to loader load_enable.
REQ-013 ld_reset  out  1  to loader reset (active-high).
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 grant_id  out  $clog2(N_REQ)  index of last accepted requester.
REQ-016 load_count  out  16  number of completed loads since reset/clear.

Function
REQ-017 FSM states SHALL be IDLE, SETUP, LOAD, CLEAR; all outputs registered.
REQ-018 IDLE with clear_req=1 SHALL go to CLEAR; clear has priority over any req_valid.
REQ-019 IDLE with clear_req=0 and any req_valid SHALL pick winner by round-robin starting at rr_ptr, assert req_ready[winner] for exactly that one cycle, capture its data, go to SETUP.
REQ-020 Transfer occurs only on req_valid[i]&&req_ready[i]; requesters SHALL hold valid and data until accepted; req_ready is never asserted for a requester with valid=0.
REQ-021 On grant, rr_ptr SHALL become (winner+1) mod N_REQ and grant_id SHALL become winner.
REQ-022 SETUP: ld_data SHALL show captured data, ld_load_enable=0, for one cycle (setup margin), then go to LOAD.
REQ-023 LOAD: ld_load_enable=1 for exactly one cycle with ld_data unchanged; load_count increments (wraps 0xFFFF->0); return to IDLE.
REQ-024 Minimum spacing between grants SHALL be 3 cycles (IDLE, SETUP, LOAD); back-to-back loads from continuously-valid requesters SHALL each take 3 cycles.
REQ-025 clear_req arriving in SETUP or LOAD SHALL NOT abort the load; it is serviced at the next IDLE.
REQ-026 CLEAR: ld_reset=1 and ld_load_enable=0 for CLR_CYCLES cycles; load_count cleared to 0 on entry; after last cycle clear_done pulses 1 cycle and FSM returns to IDLE.
REQ-027 clear_req still high after clear_done SHALL start a new CLEAR sequence.
REQ-028 ld_data SHALL hold its last value in IDLE and CLEAR.
REQ-029 Bounded latency: a continuously valid requester SHALL be granted within N_REQ grants.

Reset
REQ-030 reset low SHALL immediately force state IDLE, rr_ptr=0, grant_id=0, ld_data=0, ld_load_enable=0, ld_reset=0, req_ready=0, clear_done=0, busy=0, load_count=0.
REQ-031 reset asserted mid-SETUP/LOAD/CLEAR SHALL abandon the operation with no load_enable pulse after release; first grant after release is evaluated in IDLE from rr_ptr=0.

Structure
REQ-032 Package toy_loader_pkg SHALL hold the state enum, DATA_W default and CLR_CYCLES default.
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter (req vector + pointer in, one-hot grant + index out, combinational).

Verification
REQ-034 Single request: req_valid=0001, data0=0x3A -> req_ready[0] 1 cycle, ld_data=0x3A next cycle, ld_load_enable pulse the cycle after, load_count=1.
REQ-035 All four valid (0x11,0x22,0x33,0x44) held -> loads in order 0,1,2,3, 3 cycles apart, grant_id 0..3, load_count=4.
REQ-036 Fairness: requesters 0 and 2 always valid -> grants alternate 0,2,0,2; neither starves.
REQ-037 clear_req raised during LOAD of 0xFF -> load completes, then ld_reset high 2 cycles, clear_done pulse, load_count=0.
REQ-038 clear_req and req_valid=1111 together in IDLE -> CLEAR first, no req_ready until clear_done.
REQ-039 reset dropped in SETUP -> all outputs 0 asynchronously, no ld_load_enable pulse, next grant goes to lowest valid index.
